// File: rtl/out_port_fifo.sv
// out_port_fifo: first-word-fall-through output buffer for the CPU OUT path.
// Each OUT pushes the accumulator value; a consumer drains it over valid/ready.
// 'full' is returned to the control unit so it can stall OUT instead of dropping data.
// Optional feature: define OUT_PORT_FIFO_OVF_EN to add a sticky overflow flag
// (ovf) and its synchronous clear (ovf_clr). When the macro is undefined, both
// ports are absent and dropped writes are silent.
module out_port_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic                     m_valid,
    output logic [WIDTH-1:0]         m_data,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   count
`ifdef OUT_PORT_FIFO_OVF_EN
    ,
    output logic                     ovf,
    input  logic                     ovf_clr
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;

    logic pop;
    logic push;

    // Status outputs come only from registered state, never from inputs.
    always_comb begin
        full    = (count_q == DEPTH_C);
        m_valid = (count_q != '0);
        m_data  = mem_q[rp_q];
        count   = count_q;
    end

    // Handshake decode: a pop frees a slot that a same-edge push may reuse.
    always_comb begin
        pop  = m_valid && m_ready;
        push = wr_en && (!full || pop);
    end

    // Next-state for storage, pointers and occupancy. Pointers wrap naturally
    // because DEPTH is a power of two.
    always_comb begin
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (push) begin
            mem_d[wp_q] = wr_data;
            wp_d        = wp_q + AW'(1);
        end
        if (pop) begin
            rp_d = rp_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // FIFO state registers; reset clears storage so m_data reads zero afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q   <= '{default: '0};
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

`ifdef OUT_PORT_FIFO_OVF_EN
    logic drop;
    logic ovf_q, ovf_d;

    // Sticky overflow: a dropped write sets the flag and beats a same-cycle clear.
    always_comb begin
        drop  = wr_en && !push;
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
        ovf = ovf_q;
    end

    // Overflow flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_out_port_fifo.sv
// Testbench for out_port_fifo: queue-based reference model, directed scenarios
// from the test plan plus a randomized push/pop run. Works with or without
// OUT_PORT_FIFO_OVF_EN defined.
module tb_out_port_fifo;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             full;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;
    logic [CW-1:0]    count;
`ifdef OUT_PORT_FIFO_OVF_EN
    logic             ovf;
    logic             ovf_clr;
`endif

    always #5 clk = ~clk;

    out_port_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .count   (count)
`ifdef OUT_PORT_FIFO_OVF_EN
        ,
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
`endif
    );

    // Reference model: contents in order, plus the sticky overflow bit.
    logic [WIDTH-1:0] q[$];
    bit               mdl_ovf;
    int               n_checks;
    int               n_fail;

    // One clock cycle of stimulus; the model follows the FIFO rules directly.
    task automatic step(input logic wr, input logic [WIDTH-1:0] d,
                        input logic rdy, input logic clr);
        bit pop, push, drop;
        wr_en   = wr;
        wr_data = d;
        m_ready = rdy;
`ifdef OUT_PORT_FIFO_OVF_EN
        ovf_clr = clr;
`endif
        pop  = (q.size() != 0) && rdy;
        push = wr && ((q.size() < DEPTH) || pop);
        drop = wr && !push;
        @(posedge clk);
        #1;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(d);
        if (clr)  mdl_ovf = 1'b0;
        if (drop) mdl_ovf = 1'b1;
        wr_en   = 1'b0;
        m_ready = 1'b0;
`ifdef OUT_PORT_FIFO_OVF_EN
        ovf_clr = 1'b0;
`endif
    endtask

    // Empty the FIFO and clear the flag without checking.
    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        mdl_ovf = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (m_valid !== 1'b0) begin
                n_fail++; $display("FAIL reset_m_valid cyc %0d: got %b want 0", i, m_valid);
            end
            n_checks++;
            if (full !== 1'b0) begin
                n_fail++; $display("FAIL reset_full cyc %0d: got %b want 0", i, full);
            end
            n_checks++;
            if (count !== CW'(0)) begin
                n_fail++; $display("FAIL reset_count cyc %0d: got %0d want 0", i, count);
            end
            n_checks++;
            if (m_data !== 8'h00) begin
                n_fail++; $display("FAIL reset_m_data cyc %0d: got %h want 00", i, m_data);
            end
`ifdef OUT_PORT_FIFO_OVF_EN
            n_checks++;
            if (ovf !== 1'b0) begin
                n_fail++; $display("FAIL reset_ovf cyc %0d: got %b want 0", i, ovf);
            end
`endif
            step(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_fill_drain();
        logic [WIDTH-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        drain();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, vals[i], 1'b0, 1'b0);
            n_checks++;
            if (count !== CW'(i + 1)) begin
                n_fail++; $display("FAIL fill_count push %0d: got %0d want %0d", i, count, i + 1);
            end
        end
        n_checks++;
        if (full !== 1'b1) begin
            n_fail++; $display("FAIL fill_full: got %b want 1", full);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== vals[i]) begin
                n_fail++; $display("FAIL drain_data %0d: got v=%b d=%h want v=1 d=%h", i, m_valid, m_data, vals[i]);
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        n_checks++;
        if (m_valid !== 1'b0 || count !== CW'(0)) begin
            n_fail++; $display("FAIL drain_empty: got v=%b cnt=%0d want v=0 cnt=0", m_valid, count);
        end
    endtask

    task automatic test_full_push_pop();
        logic [WIDTH-1:0] exp [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
        drain();
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b1, 8'h44, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        n_checks++;
        if (count !== CW'(4) || full !== 1'b1) begin
            n_fail++; $display("FAIL fullpp_count: got cnt=%0d full=%b want cnt=4 full=1", count, full);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== exp[i]) begin
                n_fail++; $display("FAIL fullpp_order %0d: got v=%b d=%h want v=1 d=%h", i, m_valid, m_data, exp[i]);
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] exp [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        drain();
        for (int i = 0; i < 4; i++) step(1'b1, exp[i], 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        n_checks++;
        if (count !== CW'(4) || full !== 1'b1) begin
            n_fail++; $display("FAIL ovf_count: got cnt=%0d full=%b want cnt=4 full=1", count, full);
        end
`ifdef OUT_PORT_FIFO_OVF_EN
        n_checks++;
        if (ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf_set: got %b want 1", ovf);
        end
        step(1'b0, '0, 1'b0, 1'b1);
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clear: got %b want 0", ovf);
        end
        step(1'b1, 8'hAB, 1'b0, 1'b1);
        n_checks++;
        if (ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf_set_wins: got %b want 1", ovf);
        end
`else
        step(1'b1, 8'hAB, 1'b0, 1'b0);
`endif
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== exp[i]) begin
                n_fail++; $display("FAIL ovf_contents %0d: got v=%b d=%h want v=1 d=%h", i, m_valid, m_data, exp[i]);
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        n_checks++;
        if (m_valid !== 1'b0) begin
            n_fail++; $display("FAIL ovf_empty: got v=%b want 0", m_valid);
        end
    endtask

    task automatic test_back_to_back();
        drain();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, WIDTH'(i), 1'b1, 1'b0);
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== WIDTH'(i) || count !== CW'(1)) begin
                n_fail++; $display("FAIL stream %0d: got v=%b d=%h cnt=%0d want v=1 d=%h cnt=1",
                                   i, m_valid, m_data, count, WIDTH'(i));
            end
        end
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (m_valid !== 1'b0) begin
            n_fail++; $display("FAIL stream_end: got v=%b want 0", m_valid);
        end
    endtask

    task automatic test_mid_reset();
        drain();
        for (int i = 0; i < 3; i++) step(1'b1, 8'hC0 + WIDTH'(i), 1'b0, 1'b0);
        n_checks++;
        if (count !== CW'(3)) begin
            n_fail++; $display("FAIL midrst_pre_count: got %0d want 3", count);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (m_valid !== 1'b0 || full !== 1'b0 || count !== CW'(0)) begin
            n_fail++; $display("FAIL midrst_async: got v=%b full=%b cnt=%0d want 0 0 0", m_valid, full, count);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        mdl_ovf = 1'b0;
        step(1'b1, 8'h7E, 1'b0, 1'b0);
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h7E || count !== CW'(1)) begin
            n_fail++; $display("FAIL midrst_push: got v=%b d=%h cnt=%0d want v=1 d=7e cnt=1", m_valid, m_data, count);
        end
    endtask

    task automatic test_random();
        drain();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 6), WIDTH'($urandom), ($urandom_range(0, 9) < 5),
                 ($urandom_range(0, 15) == 0));
            n_checks++;
            if (count !== CW'(q.size()) || full !== (q.size() == DEPTH) ||
                m_valid !== (q.size() != 0)) begin
                n_fail++; $display("FAIL rand_status %0d: got cnt=%0d full=%b v=%b want cnt=%0d",
                                   i, count, full, m_valid, q.size());
            end
            if (q.size() != 0) begin
                n_checks++;
                if (m_data !== q[0]) begin
                    n_fail++; $display("FAIL rand_data %0d: got %h want %h", i, m_data, q[0]);
                end
            end
`ifdef OUT_PORT_FIFO_OVF_EN
            n_checks++;
            if (ovf !== mdl_ovf) begin
                n_fail++; $display("FAIL rand_ovf %0d: got %b want %b", i, ovf, mdl_ovf);
            end
`endif
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        wr_en    = 1'b0;
        wr_data  = '0;
        m_ready  = 1'b0;
`ifdef OUT_PORT_FIFO_OVF_EN
        ovf_clr  = 1'b0;
`endif
        test_reset();
        test_fill_drain();
        test_full_push_pop();
        test_overflow();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/out_port_fifo.md
# out_port_fifo

Output buffer between the CPU's OUT path and external consumers (display, UART, test monitor). Each OUT instruction pushes the 8-bit accumulator value into a small first-word-fall-through FIFO. The FIFO drains over a valid/ready handshake. `full` feeds back to the control unit so it can stall OUT instead of losing data.

## Interface
- `DEPTH`, default 4: number of entries; power of two, ≥2.
- `WIDTH`, default 8: data width; matches the accumulator.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clock `clk`.
- `wr_en`  in  1  push request; driven by the control unit's output-enable pulse.
- `wr_data`  in  WIDTH  value to push (accumulator register A).
- `full`  out  1  high when count == DEPTH; control unit stalls OUT while high.
- `m_valid`  out  1  head entry available; equals (count != 0).
- `m_data`  out  WIDTH  head entry; combinational read of storage at the read pointer.
- `m_ready`  in  1  consumer accepts the head entry this cycle.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `ovf`  out  1  sticky overflow flag; present only with `OUT_PORT_FIFO_OVF_EN`.
- `ovf_clr`  in  1  synchronous clear of `ovf`; present only with `OUT_PORT_FIFO_OVF_EN`.

## Operation
- Storage: DEPTH×WIDTH register array, plus write pointer `wp`, read pointer `rp` and `count`.
- Pop: `pop = m_valid && m_ready`. On pop, `rp` ← `rp`+1, wrapping modulo DEPTH.
- Push: `push = wr_en && (count < DEPTH || pop)`. On push, store `wr_data` at `wp`, then `wp` ← `wp`+1, wrapping modulo DEPTH.
- Count update: push and pop together leave `count` unchanged. Push alone adds 1. Pop alone subtracts 1.
- Full with simultaneous pop: the push is accepted. The entry freed by the pop is reused in the same edge.
- Empty with simultaneous push and `m_ready`: no pop occurs, because `m_valid` is 0. The data appears at the head next cycle. There is no bypass.
- Dropped write: `wr_en` while full and no pop. Data is discarded and pointers and count are unchanged.
- `m_data` is defined only while `m_valid` is 1. After reset it reads 0, because storage clears on reset.
- Ordering is strict FIFO. No entry is duplicated or skipped across pointer wrap-around.
- Reset reaction is asynchronous: while `reset` is high, `wp`, `rp` and `count` are 0 and storage is 0. Consequences:
  - `m_valid`, `full` and `ovf` are 0.
  - Any in-flight entries are lost.
  - The first edge after release can already accept a push.

## Timing
- Push-to-visible latency is 1 cycle: a push at edge N gives `m_valid` = 1 and head `m_data` from just after edge N.
- Pop takes effect at the edge. The next entry is on `m_data` in the following cycle; there are no bubbles between back-to-back entries.
- Sustained throughput is one push and one pop per cycle at any occupancy from 1 to DEPTH.
- `full` updates one cycle after the push that fills the FIFO.
  - The control unit samples `full` before issuing `wr_en`.
  - A `wr_en` issued in the same cycle that `full` rises follows the dropped-write rule.
- `count`, `full` and `m_valid` are all derived from registered state; no input reaches them combinationally.

## Configuration
- Macro `OUT_PORT_FIFO_OVF_EN`.
- Defined:
  - `ovf` and `ovf_clr` exist.
  - `ovf` is set at the edge of any dropped write and stays 1 until `ovf_clr` or reset.
  - If `ovf_clr` and a dropped write happen in the same cycle, set wins.
  - `ovf` has no effect on FIFO data flow.
- Undefined: both ports and the flag register are omitted, and dropped writes are silent.

## Test plan
- Reset then idle: after `reset` pulse, `m_valid`=0, `full`=0, `count`=0, `m_data`=8'h00; holds for 10 cycles with `m_ready`=1.
- Fill and drain in order: with `m_ready`=0, push 8'h11, 8'h22, 8'h33, 8'h44 on consecutive cycles.
  - After the 4th edge: `full`=1, `count`=4.
  - Then `m_ready`=1: `m_data` shows 11, 22, 33, 44 on consecutive cycles, then `m_valid`=0.
- Full with simultaneous push and pop: FIFO holding 11,22,33,44, push 8'h55 with `m_ready`=1.
  - Expect `count` to stay 4.
  - Drain order must be 22,33,44,55.
- Overflow: FIFO full, `m_ready`=0, push 8'hAA.
  - `count` stays 4 and the contents are unchanged.
  - With the macro, `ovf`=1 after the edge; `ovf_clr` clears it next cycle.
  - Pulse `ovf_clr` together with a dropped write: `ovf` stays 1.
- Wrap-around streaming: 20 pushes of 0..19 with `m_ready`=1 throughout.
  - Each value appears one cycle after its push and `count` never exceeds 1.
  - Output sequence is exactly 0..19.
- Reset mid-operation: with `count`=3, assert `reset` asynchronously between edges.
  - `m_valid`, `full` and `count` drop to 0 immediately.
  - After release, push 8'h7E: `m_data`=7E with `m_valid`=1 the next cycle.
